branch_pred_decoder: RTL and testbench

BRANCH_PRED_DECODER -- requirements
Module: branch_pred_decoder

---
 rtl/branch_pred_decoder.sv | 125 ++++++++++++
 tb/tb_branch_pred_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_decoder.sv
// branch_pred_decoder: RV32IC fetch-stage control-flow decoder with a 2-bit BHT and an optional return-address stack
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (low holds all state)
//   _br_rob/_rob_new_pc/_rob_imm : ROB redirect, target = base + offset
//   _clear                       : pipeline flush
//   _inst_in/_inst_ready_in/_inst_addr : fetched instruction, valid, and its PC
//   _upd_valid/_upd_pc/_upd_taken : resolved conditional branch training the BHT
//   _next_pc, _stall, _rvc, _pred_taken : fetch steering outputs
// Define BRANCH_PRED_RAS_EN to build the return-address stack; without it every jalr stalls.
module branch_pred_decoder #(
  parameter int BHT_IDX_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _br_rob,
  input  logic [31:0] _rob_new_pc,
  input  logic [31:0] _rob_imm,
  input  logic        _clear,
  input  logic [31:0] _inst_in,
  input  logic        _inst_ready_in,
  input  logic [31:0] _inst_addr,
  input  logic        _upd_valid,
  input  logic [31:0] _upd_pc,
  input  logic        _upd_taken,
  output logic [31:0] _next_pc,
  output logic        _stall,
  output logic        _rvc,
  output logic        _pred_taken
);
  localparam int NB = 1 << BHT_IDX_W;
  logic [2:0] f3c;
  logic c_j, c_jr, c_br, is_jal, is_jalr, is_br, ras_hit;
  logic [31:0] step, seq_pc, jal_imm, br_imm, ras_top;
  logic [1:0] bht_q [NB];
  logic [1:0] bht_d [NB];
  logic [1:0] upd_cnt;
  logic [BHT_IDX_W-1:0] rd_idx, up_idx;
  logic unused_ok;
  assign f3c = _inst_in[15:13];
  assign _rvc = _inst_in[1:0] != 2'b11;
  assign step = _rvc ? 32'd2 : 32'd4;
  assign seq_pc = _inst_addr + step;
  // C.JAL (001) and C.J (101) share quadrant 1 and differ only in funct3[2]
  assign c_j = _inst_in[1:0] == 2'b01 && f3c[1:0] == 2'b01;
  assign c_jr = _inst_in[1:0] == 2'b10 && f3c == 3'b100 && _inst_in[6:2] == 5'd0 && _inst_in[11:7] != 5'd0;
  assign c_br = _inst_in[1:0] == 2'b01 && f3c[2:1] == 2'b11;
  assign is_jal = c_j || _inst_in[6:0] == 7'b1101111;
  assign is_jalr = c_jr || _inst_in[6:0] == 7'b1100111;
  assign is_br = c_br || _inst_in[6:0] == 7'b1100011;
  assign jal_imm = _rvc
    ? {{20{_inst_in[12]}}, _inst_in[12], _inst_in[8], _inst_in[10:9], _inst_in[6], _inst_in[7],
       _inst_in[2], _inst_in[11], _inst_in[5:3], 1'b0}
    : {{12{_inst_in[31]}}, _inst_in[19:12], _inst_in[20], _inst_in[30:21], 1'b0};
  assign br_imm = _rvc
    ? {{23{_inst_in[12]}}, _inst_in[12], _inst_in[6:5], _inst_in[2], _inst_in[11:10], _inst_in[4:3], 1'b0}
    : {{20{_inst_in[31]}}, _inst_in[7], _inst_in[30:25], _inst_in[11:8], 1'b0};
  assign rd_idx = _inst_addr[BHT_IDX_W:1];
  assign up_idx = _upd_pc[BHT_IDX_W:1];
  assign upd_cnt = bht_q[up_idx];
  assign unused_ok = ^{_upd_pc[31:BHT_IDX_W+1], _upd_pc[0]};
  assign _pred_taken = _inst_ready_in && is_br && bht_q[rd_idx][1];
  assign _stall = !_br_rob && !_clear && _inst_ready_in && is_jalr && !ras_hit;
  assign _next_pc = _br_rob ? _rob_new_pc + _rob_imm
                  : !_inst_ready_in ? _inst_addr
                  : is_jal ? _inst_addr + jal_imm
                  : (is_jalr && ras_hit) ? ras_top
                  : (is_br && _pred_taken) ? _inst_addr + br_imm
                  : seq_pc;
  always_comb begin
    bht_d = bht_q;
    if (rdy_in && _upd_valid)
      bht_d[up_idx] = _upd_taken ? (upd_cnt == 2'b11 ? 2'b11 : upd_cnt + 2'd1)
                                 : (upd_cnt == 2'b00 ? 2'b00 : upd_cnt - 2'd1);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) bht_q <= '{default: 2'b01};
    else bht_q <= bht_d;
  end
`ifdef BRANCH_PRED_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [31:0] ras_q [RAS_DEPTH];
  logic [31:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d, top;
  logic [PW:0] cnt_q, cnt_d;
  logic is_call, is_ret, fetch;
  assign is_call = c_j ? !f3c[2] : c_jr ? _inst_in[12] : (is_jal || is_jalr) && _inst_in[11:7] == 5'd1;
  assign is_ret = c_jr ? !_inst_in[12] && _inst_in[11:7] == 5'd1
                : is_jalr && _inst_in[11:7] == 5'd0 && _inst_in[19:15] == 5'd1 && _inst_in[31:20] == 12'd0;
  // ptr_q is the next free slot; the stack is circular so a full push overwrites the oldest entry
  assign top = ptr_q - PW'(1);
  assign ras_top = ras_q[top];
  assign ras_hit = is_ret && cnt_q != '0;
  assign fetch = rdy_in && _inst_ready_in && !_br_rob && !_clear && !_stall;
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (rdy_in && (_br_rob || _clear)) cnt_d = '0;
    else if (fetch && is_call && ras_hit) ras_d[top] = seq_pc;
    else if (fetch && is_call) begin
      ras_d[ptr_q] = seq_pc;
      ptr_d = ptr_q + PW'(1);
      cnt_d = cnt_q == (PW+1)'(RAS_DEPTH) ? cnt_q : cnt_q + (PW+1)'(1);
    end else if (fetch && ras_hit) begin
      ptr_d = top;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end
  always_ff @(posedge clk_in) begin
    ras_q <= ras_d;
    if (rst_in) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
`else
  assign ras_hit = 1'b0;
  assign ras_top = seq_pc;
`endif
endmodule

// File: tb/tb_branch_pred_decoder.sv
// tb_branch_pred_decoder: directed and random checks of branch_pred_decoder against a behavioural model
module tb_branch_pred_decoder;
  localparam int NB = 64;
  localparam int DEPTH = 4;
  localparam int K_OTHER = 0, K_JAL = 1, K_JALR = 2, K_BR = 3;
`ifdef BRANCH_PRED_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, rdy, br_rob, clr, inst_ready, upd_valid, upd_taken;
  logic [31:0] rob_new_pc, rob_imm, inst, inst_addr, upd_pc;
  logic [31:0] next_pc;
  logic stall, rvc, pred_taken;
  int tests = 0;
  int fails = 0;
  int bht [NB];
  logic [31:0] ras [$];
  int d_kind;
  logic [31:0] d_imm;
  bit d_call, d_ret, d_rvc;

  branch_pred_decoder dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    ._br_rob(br_rob), ._rob_new_pc(rob_new_pc), ._rob_imm(rob_imm), ._clear(clr),
    ._inst_in(inst), ._inst_ready_in(inst_ready), ._inst_addr(inst_addr),
    ._upd_valid(upd_valid), ._upd_pc(upd_pc), ._upd_taken(upd_taken),
    ._next_pc(next_pc), ._stall(stall), ._rvc(rvc), ._pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_meta(input int k, input logic [31:0] imm, input bit call, input bit ret, input bit c);
    d_kind = k; d_imm = imm; d_call = call; d_ret = ret; d_rvc = c;
  endtask

  task automatic set_jal(input logic [4:0] rd, input logic [31:0] imm);
    inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    set_meta(K_JAL, imm, rd == 5'd1, 1'b0, 1'b0);
  endtask

  task automatic set_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    inst = {imm, rs1, 3'b000, rd, 7'b1100111};
    set_meta(K_JALR, 32'd0, rd == 5'd1, rd == 5'd0 && rs1 == 5'd1 && imm == 12'd0, 1'b0);
  endtask

  task automatic set_br(input logic [31:0] imm);
    inst = {imm[12], imm[10:5], 5'($urandom), 5'($urandom), 3'($urandom), imm[4:1], imm[11], 7'b1100011};
    set_meta(K_BR, imm, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_alu();
    inst = {25'($urandom), 7'b0010011};
    set_meta(K_OTHER, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cj(input bit link, input logic [31:0] imm);
    inst = {16'($urandom), link ? 3'b001 : 3'b101, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7],
            imm[3:1], imm[5], 2'b01};
    set_meta(K_JAL, imm, link, 1'b0, 1'b1);
  endtask

  task automatic set_cjr(input bit link, input logic [4:0] rs1);
    inst = {16'($urandom), 3'b100, link, rs1, 5'd0, 2'b10};
    set_meta(K_JALR, 32'd0, link, !link && rs1 == 5'd1, 1'b1);
  endtask

  task automatic set_cb(input bit nz, input logic [31:0] imm);
    inst = {16'($urandom), 2'b11, nz, imm[8], imm[4:3], 3'($urandom), imm[7:6], imm[2:1], imm[5], 2'b01};
    set_meta(K_BR, imm, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic set_calu();
    inst = {16'($urandom), 3'b000, 11'($urandom), 2'b00};
    set_meta(K_OTHER, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_cycle(input string tag);
    logic [31:0] e_pc, stp;
    logic e_stall, e_pt, hit;
    int idx, u;
    stp = d_rvc ? 32'd2 : 32'd4;
    idx = int'((inst_addr >> 1) % NB);
    hit = RAS_ON && inst_ready && d_kind == K_JALR && d_ret && ras.size() > 0;
    e_pt = inst_ready && d_kind == K_BR && bht[idx] >= 2;
    if (br_rob) e_pc = rob_new_pc + rob_imm;
    else if (!inst_ready) e_pc = inst_addr;
    else if (d_kind == K_JAL) e_pc = inst_addr + d_imm;
    else if (hit) e_pc = ras[$];
    else if (d_kind == K_BR && e_pt) e_pc = inst_addr + d_imm;
    else e_pc = inst_addr + stp;
    e_stall = !br_rob && !clr && inst_ready && d_kind == K_JALR && !hit;
    #1;
    chk({tag, ".next_pc"}, next_pc, e_pc);
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".rvc"}, 32'(rvc), 32'(d_rvc));
    chk({tag, ".pred_taken"}, 32'(pred_taken), 32'(e_pt));
    @(posedge clk);
    if (rst) begin
      foreach (bht[i]) bht[i] = 1;
      ras.delete();
    end else if (rdy) begin
      if (upd_valid) begin
        u = int'((upd_pc >> 1) % NB);
        bht[u] = upd_taken ? (bht[u] < 3 ? bht[u] + 1 : 3) : (bht[u] > 0 ? bht[u] - 1 : 0);
      end
      if (br_rob || clr) ras.delete();
      else if (inst_ready && !e_stall) begin
        if (hit) void'(ras.pop_back());
        if (d_call) begin
          ras.push_back(inst_addr + stp);
          if (ras.size() > DEPTH) void'(ras.pop_front());
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] r;
    int k;
    rst = 1; rdy = 0; br_rob = 0; clr = 0; inst_ready = 0;
    upd_valid = 1; upd_taken = 1; upd_pc = 32'h100;
    rob_new_pc = 0; rob_imm = 0; inst_addr = 32'h40;
    set_alu();
    run_cycle("reset");
    rst = 0; rdy = 1; upd_valid = 0;
    #1 chk("post_reset.next_pc", next_pc, 32'h40);
    run_cycle("post_reset");
    inst_ready = 1; inst_addr = 32'h100; set_br(32'h40);
    #1 chk("br_init.next_pc", next_pc, 32'h104);
    chk("br_init.pred", 32'(pred_taken), 32'd0);
    run_cycle("br_init");
    inst_ready = 0; upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
    run_cycle("upd_t1");
    run_cycle("upd_t2");
    upd_valid = 0; inst_ready = 1;
    #1 chk("br_taken.next_pc", next_pc, 32'h140);
    chk("br_taken.pred", 32'(pred_taken), 32'd1);
    run_cycle("br_taken");
    upd_valid = 1; upd_taken = 0;
    run_cycle("same_cycle_rd_upd");
    inst_ready = 0;
    run_cycle("upd_n2");
    run_cycle("upd_n3");
    run_cycle("upd_n4_sat");
    upd_taken = 1;
    run_cycle("upd_t_from_sat");
    upd_valid = 0; inst_ready = 1;
    #1 chk("br_after_sat.pred", 32'(pred_taken), 32'd0);
    run_cycle("br_after_sat");
    rdy = 0; inst_ready = 0; upd_valid = 1; upd_taken = 1;
    run_cycle("hold_rdy0_a");
    run_cycle("hold_rdy0_b");
    rdy = 1; upd_valid = 0; inst_ready = 1;
    run_cycle("br_after_hold");
    inst_ready = 0; upd_valid = 1; upd_pc = 32'h202; upd_taken = 1;
    run_cycle("upd_202_a");
    run_cycle("upd_202_b");
    upd_valid = 0; inst_ready = 1; inst_addr = 32'h202; set_cb(1'b1, 32'hFFFF_FFFC);
    #1 chk("cbnez.next_pc", next_pc, 32'h1FE);
    chk("cbnez.rvc", 32'(rvc), 32'd1);
    run_cycle("cbnez");
    inst_addr = 32'h300; set_jal(5'd1, 32'h200);
    run_cycle("jal_ra");
    inst_addr = 32'h500; set_jalr(5'd0, 5'd1, 12'd0);
    #1 chk("ret.next_pc", next_pc, RAS_ON ? 32'h304 : 32'h504);
    chk("ret.stall", 32'(stall), RAS_ON ? 32'd0 : 32'd1);
    run_cycle("ret");
    inst_addr = 32'h600; set_cj(1'b1, 32'h100);
    run_cycle("cjal");
    inst_addr = 32'h700; set_jalr(5'd0, 5'd5, 12'd0);
    br_rob = 1; rob_new_pc = 32'h1000; rob_imm = 32'd8;
    #1 chk("redirect.next_pc", next_pc, 32'h1008);
    chk("redirect.stall", 32'(stall), 32'd0);
    run_cycle("redirect");
    br_rob = 0; inst_addr = 32'h1008; set_cjr(1'b0, 5'd1);
    #1 chk("ret_after_flush.stall", 32'(stall), 32'd1);
    run_cycle("ret_after_flush");
    for (int i = 0; i <= DEPTH; i++) begin
      inst_addr = 32'h2000 + 32'(i) * 32'h10;
      if (i % 2 == 0) set_jal(5'd1, 32'h40); else set_cj(1'b1, 32'h40);
      run_cycle($sformatf("call%0d", i));
    end
    for (int i = 0; i <= DEPTH; i++) begin
      inst_addr = 32'h3000 + 32'(i) * 32'h8;
      if (i % 2 == 0) set_jalr(5'd0, 5'd1, 12'd0); else set_cjr(1'b0, 5'd1);
      run_cycle($sformatf("ret%0d", i));
    end
    for (int n = 0; n < 500; n++) begin
      r = $urandom;
      k = $urandom_range(0, 11);
      rst = $urandom_range(0, 59) == 0;
      rdy = $urandom_range(0, 9) != 0;
      br_rob = $urandom_range(0, 19) == 0;
      clr = $urandom_range(0, 19) == 0;
      rob_new_pc = $urandom; rob_imm = $urandom;
      inst_ready = $urandom_range(0, 7) != 0;
      inst_addr = {21'd0, 10'($urandom), 1'b0};
      upd_valid = 1'($urandom); upd_taken = 1'($urandom);
      upd_pc = {21'd0, 10'($urandom), 1'($urandom)};
      case (k)
        0: set_jal(5'd1, {{11{r[20]}}, r[20:1], 1'b0});
        1: set_jal(5'($urandom), {{11{r[20]}}, r[20:1], 1'b0});
        2: set_jalr(5'd0, 5'd1, 12'd0);
        3: set_cjr(1'b0, 5'd1);
        4: set_cjr(1'b1, 5'($urandom_range(1, 31)));
        5: set_jalr(5'($urandom), 5'($urandom), 12'($urandom));
        6: set_cj(r[0], {{20{r[11]}}, r[11:1], 1'b0});
        7, 8: set_br({{19{r[12]}}, r[12:1], 1'b0});
        9: set_cb(r[0], {{23{r[8]}}, r[8:1], 1'b0});
        10: set_alu();
        default: set_calu();
      endcase
      run_cycle($sformatf("rand%0d", n));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
